// File: rtl/vector_alu_engine.sv
// Memory-resident vector ALU: streams c[i] = op(a[i], b[i]) over an internal
// DEPTH-word memory at one element per cycle, with a host port used while idle.
module vector_alu_engine #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] c_base,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  idle,
  output logic                  done,
  output logic                  ovf,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_SADD = 2'd2;
  localparam logic [1:0] OP_ABSD = 2'd3;

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [ADDR_WIDTH-1:0]   a_ptr_q, a_ptr_d;
  logic [ADDR_WIDTH-1:0]   b_ptr_q, b_ptr_d;
  logic [ADDR_WIDTH-1:0]   c_ptr_q, c_ptr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    idle_q, idle_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we_c;
  logic [ADDR_WIDTH-1:0]   mem_waddr_c;
  logic [DATA_WIDTH-1:0]   mem_wdata_c;
  logic [DATA_WIDTH-1:0]   a_val_c, b_val_c;
  logic [DATA_WIDTH:0]     sum_c, diff_c;
  logic [DATA_WIDTH-1:0]   res_c;
  logic                    wrap_c;

  assign a_val_c    = mem_q[a_ptr_q];
  assign b_val_c    = mem_q[b_ptr_q];
  assign host_rdata = mem_q[host_addr];

  // Element ALU; the extra MSB of sum/diff is the carry/borrow
  always_comb begin
    sum_c  = {1'b0, a_val_c} + {1'b0, b_val_c};
    diff_c = {1'b0, a_val_c} - {1'b0, b_val_c};
    res_c  = sum_c[DATA_WIDTH-1:0];
    wrap_c = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_c  = sum_c[DATA_WIDTH-1:0];
        wrap_c = sum_c[DATA_WIDTH];
      end
      OP_SUB: begin
        res_c  = diff_c[DATA_WIDTH-1:0];
        wrap_c = diff_c[DATA_WIDTH];
      end
      OP_SADD: res_c = sum_c[DATA_WIDTH] ? '1 : sum_c[DATA_WIDTH-1:0];
      OP_ABSD: res_c = diff_c[DATA_WIDTH] ? (b_val_c - a_val_c) : diff_c[DATA_WIDTH-1:0];
      default: res_c = sum_c[DATA_WIDTH-1:0];
    endcase
  end

  // Next-state, job latching and the single memory write port
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_ptr_d     = a_ptr_q;
    b_ptr_d     = b_ptr_q;
    c_ptr_d     = c_ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = host_addr;
    mem_wdata_c = host_wdata;

    case (state_q)
      S_IDLE: begin
        mem_we_c = host_we;
        if (start) begin
          op_d    = op;
          a_ptr_d = a_base;
          b_ptr_d = b_base;
          c_ptr_d = c_base;
          cnt_d   = count;
          ovf_d   = 1'b0;
          state_d = (count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = c_ptr_q;
        mem_wdata_c = res_c;
        ovf_d       = ovf_q | wrap_c;
        a_ptr_d     = a_ptr_q + ADDR_WIDTH'(1);
        b_ptr_d     = b_ptr_q + ADDR_WIDTH'(1);
        c_ptr_d     = c_ptr_q + ADDR_WIDTH'(1);
        cnt_d       = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    idle_d = (state_d == S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      c_ptr_q <= '0;
      cnt_q   <= '0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_ptr_q <= a_ptr_d;
      b_ptr_q <= b_ptr_d;
      c_ptr_q <= c_ptr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Memory contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  assign idle = idle_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_vector_alu_engine.sv
// Directed self-checking bench for vector_alu_engine with hand-computed results.
module tb_vector_alu_engine;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 6;
  localparam int unsigned CW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] a_base, b_base, c_base;
  logic [CW-1:0] count;
  logic          idle, done, ovf;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  vector_alu_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_base(a_base), .b_base(b_base), .c_base(c_base), .count(count),
    .idle(idle), .done(done), .ovf(ovf),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    host_addr = addr;
    #1;
    chk(tag, 32'(host_rdata), 32'(exp));
  endtask

  // Drives start for one cycle (cycle T); returns in cycle T+1
  task automatic start_job(input logic [1:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] c, input logic [CW-1:0] n);
    op = o; a_base = a; b_base = b; c_base = c; count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From cycle T+1, step to T+1+n checking done timing, then one more into IDLE
  task automatic finish_job(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) chk({tag, "_done_early"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    tick();
    chk({tag, "_idle_back"}, 32'(idle), 32'd1);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    rst_n = 1'b0; start = 1'b0; op = 2'd0;
    a_base = '0; b_base = '0; c_base = '0; count = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #12;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      host_write(AW'(20 + i), DW'(1 + i));
      host_write(AW'(30 + i), DW'(100 + i));
    end

    // ADD, 10 elements
    start_job(2'd0, 6'd20, 6'd30, 6'd10, 7'd10);
    chk("add_idle_fall", 32'(idle), 32'd0);
    finish_job("add", 10);
    chk("add_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 10; i++) check_mem("add_res", AW'(10 + i), DW'(101 + 2 * i));

    // SUB with borrow: 5 - 7
    host_write(6'd40, 16'd5);
    host_write(6'd41, 16'd7);
    start_job(2'd1, 6'd40, 6'd41, 6'd42, 7'd1);
    chk("sub_ovf_T1", 32'(ovf), 32'd0);
    tick();
    chk("sub_done", 32'(done), 32'd1);
    chk("sub_ovf_T2", 32'(ovf), 32'd1);
    tick();
    tick();
    chk("sub_ovf_sticky", 32'(ovf), 32'd1);
    check_mem("sub_res", 6'd42, 16'hFFFE);

    // SADD clamps, and the accepted start clears ovf
    host_write(6'd43, 16'hFFF0);
    host_write(6'd44, 16'h0020);
    start_job(2'd2, 6'd43, 6'd44, 6'd45, 7'd1);
    chk("sadd_ovf_clr", 32'(ovf), 32'd0);
    finish_job("sadd", 1);
    chk("sadd_ovf", 32'(ovf), 32'd0);
    check_mem("sadd_res", 6'd45, 16'hFFFF);

    // ADD wrap of the same operands sets ovf
    start_job(2'd0, 6'd43, 6'd44, 6'd49, 7'd1);
    finish_job("addw", 1);
    chk("addw_ovf", 32'(ovf), 32'd1);
    check_mem("addw_res", 6'd49, 16'h0010);

    // ABSDIFF both orderings: |3-10| and |10-3|
    host_write(6'd46, 16'd3);
    host_write(6'd47, 16'd10);
    start_job(2'd3, 6'd46, 6'd47, 6'd48, 7'd1);
    finish_job("absd", 1);
    chk("absd_ovf", 32'(ovf), 32'd0);
    check_mem("absd_res", 6'd48, 16'd7);
    start_job(2'd3, 6'd47, 6'd46, 6'd48, 7'd1);
    finish_job("absd2", 1);
    check_mem("absd2_res", 6'd48, 16'd7);

    // Pointer wrap and read-after-write aliasing
    host_write(6'd62, 16'd1);
    start_job(2'd0, 6'd62, 6'd62, 6'd63, 7'd3);
    finish_job("wrap", 3);
    check_mem("wrap_m63", 6'd63, 16'd2);
    check_mem("wrap_m0",  6'd0,  16'd4);
    check_mem("wrap_m1",  6'd1,  16'd8);

    // Zero-count job
    host_write(6'd5, 16'hABCD);
    start_job(2'd0, 6'd20, 6'd30, 6'd5, 7'd0);
    finish_job("zero", 0);
    check_mem("zero_nowrite", 6'd5, 16'hABCD);

    // start and host writes during RUN are ignored
    host_write(6'd50, 16'h5555);
    host_write(6'd55, 16'h7777);
    for (int i = 0; i < 10; i++) host_write(AW'(10 + i), 16'd0);
    start_job(2'd0, 6'd20, 6'd30, 6'd10, 7'd10);
    start = 1'b1; op = 2'd1; c_base = 6'd55; count = 7'd1;
    host_we = 1'b1; host_addr = 6'd50; host_wdata = 16'h1234;
    tick(); tick(); tick();
    start = 1'b0; host_we = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("prot_done", 32'(done), 32'd1);
    tick();
    chk("prot_idle", 32'(idle), 32'd1);
    tick(); tick();
    chk("prot_no_restart", 32'(idle), 32'd1);
    check_mem("prot_host_drop", 6'd50, 16'h5555);
    check_mem("prot_start_drop", 6'd55, 16'h7777);
    for (int i = 0; i < 10; i++) check_mem("prot_res", AW'(10 + i), DW'(101 + 2 * i));

    // Reset mid-job just before element 4 commits
    for (int i = 0; i < 10; i++) host_write(AW'(10 + i), 16'd0);
    start_job(2'd0, 6'd20, 6'd30, 6'd10, 7'd10);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_idle", 32'(idle), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) dcount++;
      tick();
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    for (int i = 0; i < 4; i++) check_mem("abort_written", AW'(10 + i), DW'(101 + 2 * i));
    for (int i = 4; i < 10; i++) check_mem("abort_untouched", AW'(10 + i), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_alu_engine.md
# vector_alu_engine

Parametrised successor to the single-op vector adder microbenchmark. Holds an internal DEPTH-word memory, accepts a job descriptor on a start/idle handshake, and streams `c[i] = op(a[i], b[i])` for `count` elements at one element per cycle. Supports four element ops, including a saturating one, and a sticky overflow flag. A host port loads operands and reads results while the engine is idle. It is the memory-bound kernel used by the memory microbenchmarks and their self-checking testers.

## Interface
- `DATA_WIDTH`, 16, element width in bits.
- `ADDR_WIDTH`, 6, address width; DEPTH = 2**ADDR_WIDTH words.
- `CNT_WIDTH`, ADDR_WIDTH+1, width of `count`, so one job can cover the full memory.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `op`  in  2  00 ADD wrap, 01 SUB wrap (a-b), 10 ADD saturating unsigned, 11 unsigned absolute difference.
- `a_base`, `b_base`, `c_base`  in  ADDR_WIDTH each  base addresses of the two operand vectors and the result vector.
- `count`  in  CNT_WIDTH  number of elements.
- `idle`  out  1  high in IDLE.
- `done`  out  1  one-cycle pulse at job completion.
- `ovf`  out  1  sticky: a wrap occurred in the current or last job.
- `host_we`  in  1  host write enable.
- `host_addr`  in  ADDR_WIDTH  host address.
- `host_wdata`  in  DATA_WIDTH  host write data.
- `host_rdata`  out  DATA_WIDTH  combinational `mem[host_addr]`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`=1 with `count`!=0.
  - IDLE -> DONE on `start`=1 with `count`==0.
  - RUN -> DONE when the element with remaining count 1 is issued.
  - DONE -> IDLE unconditionally.
- On an accepted `start`:
  - latch `op`, all three bases and `count`.
  - clear `ovf`.
  - a `start` seen in RUN or DONE is ignored.
- In RUN, each cycle:
  - read `mem[a_ptr]` and `mem[b_ptr]` combinationally.
  - write the result to `mem[c_ptr]` at the clock edge.
  - increment all three pointers and decrement the remaining count.
- Pointer increments wrap modulo DEPTH.
- Arithmetic is DATA_WIDTH-bit unsigned:
  - ADD: low bits of a+b; sets `ovf` on carry-out.
  - SUB: low bits of a-b; sets `ovf` on borrow (a<b).
  - SADD: a+b, clamped to all-ones on carry; never sets `ovf`.
  - ABSDIFF: |a-b|; never sets `ovf`.
- Aliasing: element i sees every write from elements 0..i-1, because reads are combinational and writes commit at the edge. In-place operation (`c_base`==`a_base`) is legal.
- Host port:
  - `host_we` is honoured only in IDLE; in RUN and DONE it is dropped silently.
  - `host_rdata` is valid in every state.
  - In IDLE, a `start` and a host write in the same cycle are both taken; the host write commits first, so it is visible to element 0.
- Reset (`rst_n`=0, asynchronous):
  - state goes to IDLE; `idle`=1, `done`=0, `ovf`=0.
  - pointers and the latched count go to 0.
  - memory contents are not reset.
  - a reset during RUN aborts the job: elements already written stay written, and no `done` is produced.

## Timing
- `start` accepted in cycle T:
  - RUN from T+1.
  - element i written at the end of cycle T+1+i.
  - `done`=1 in cycle T+1+count.
  - `idle`=1 again from T+2+count.
- Zero-count job: `done` in T+1, `idle` in T+2, no memory writes.
- `idle` falls in T+1.
- `ovf` updates in the cycle after the offending element and holds until the next accepted `start` or reset.
- Throughput: one element per cycle. Minimum job-to-job spacing is count+2 cycles.

## Test plan
- Reset then idle: `idle`=1, `done`=0, `ovf`=0.
  - Host writes 1..10 at 20..29 and 100..109 at 30..39.
  - ADD with `count`=10, `c_base`=10, `start` at T -> `mem[10..19]` = 101,103,...,119; `done` at T+11; `ovf`=0.
- SUB with `mem[a]`=5, `mem[b]`=7, `count`=1 -> result 0xFFFE; `ovf`=1 at T+2; `ovf` stays 1 until the next `start`, then reads 0.
- SADD of 0xFFF0+0x0020 -> 0xFFFF, `ovf`=0. ABSDIFF of 3 and 10 -> 7.
- Wrap and alias:
  - `a_base`=62, `b_base`=62, `c_base`=63, DEPTH=64, `count`=3, `mem[62]`=1, ADD -> writes `mem[63]`=2, `mem[0]`=4, `mem[1]`=`mem[0]`+`mem[0]` using the just-written value 4, giving 8.
  - `count`=0 -> `done` at T+1 with no writes.
- Protocol: `start` and host writes during RUN are ignored, with the memory image unchanged apart from the job's own results. Assert `rst_n`=0 mid-job at element 4 of 10 -> elements 0..3 written, 4..9 untouched, `idle`=1 immediately, no `done`.
